// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial bit-sequence detector.
// The pattern, its length (1..MAX_LEN) and overlap mode are loaded at run time.
// A registered one-cycle match pulse and a saturating match counter are produced.
// Optional feature macro SEQ_DETECT_MASK_EN adds a per-bit care_mask input.
// The mask is latched on a legal load. Cleared mask bits are don't-care in the compare.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               sequence_in,
    input  logic               clr_count,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [MAX_LEN-1:0] care_mask,
`endif
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

    stateT              state_q, state_d;
    logic [MAX_LEN-1:0] cfgPattern_q, cfgPattern_d;
    logic [LEN_W-1:0]   cfgLen_q, cfgLen_d;
    logic               cfgOverlap_q, cfgOverlap_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detect_q, detect_d;
    logic               cfgErr_q, cfgErr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN-1:0] careMask;
    logic [MAX_LEN-1:0] lenMask;
    logic [MAX_LEN-1:0] shiftedHistory;
    logic [LEN_W-1:0]   bumpedFill;
    logic               loadLegal;
    logic               patternHit;

`ifdef SEQ_DETECT_MASK_EN
    logic [MAX_LEN-1:0] cfgMask_q, cfgMask_d;
    assign careMask = cfgMask_q;
`else
    assign careMask = '1;
`endif

    assign loadLegal      = (pat_len != '0) && (pat_len <= MaxLenL);
    assign shiftedHistory = {history_q[MAX_LEN-2:0], sequence_in};
    assign bumpedFill     = (fill_q >= MaxLenL) ? MaxLenL : fill_q + LEN_W'(1);

    // Select only the bit positions that belong to the active pattern length.
    always_comb begin
        lenMask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(cfgLen_q));
        end
    end

    // A match needs enough fresh bits and agreement on every cared-for position.
    assign patternHit = ((((shiftedHistory ^ cfgPattern_q) & careMask & lenMask) == '0)
                         && (bumpedFill >= cfgLen_q));

    // Next-state, configuration, history/fill and counter updates.
    always_comb begin
        state_d      = state_q;
        cfgPattern_d = cfgPattern_q;
        cfgLen_d     = cfgLen_q;
        cfgOverlap_d = cfgOverlap_q;
        history_d    = history_q;
        fill_d       = fill_q;
        detect_d     = 1'b0;
        cfgErr_d     = 1'b0;
        count_d      = count_q;
`ifdef SEQ_DETECT_MASK_EN
        cfgMask_d    = cfgMask_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (load && loadLegal) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            if (loadLegal) begin
                cfgPattern_d = pattern;
                cfgLen_d     = pat_len;
                cfgOverlap_d = overlap;
                history_d    = '0;
                fill_d       = '0;
`ifdef SEQ_DETECT_MASK_EN
                cfgMask_d    = care_mask;
`endif
            end else begin
                cfgErr_d = 1'b1;
            end
        end else if ((state_q == RUN) && in_valid) begin
            history_d = shiftedHistory;
            fill_d    = bumpedFill;
            if (patternHit) begin
                detect_d = 1'b1;
                if (!cfgOverlap_q) begin
                    fill_d = '0;
                end
            end
        end

        if (clr_count) begin
            count_d = '0;
        end else if (detect_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: configuration, shift history, fill, pulses and counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfgPattern_q <= '0;
            cfgLen_q     <= '0;
            cfgOverlap_q <= 1'b0;
            history_q    <= '0;
            fill_q       <= '0;
            detect_q     <= 1'b0;
            cfgErr_q     <= 1'b0;
            count_q      <= '0;
`ifdef SEQ_DETECT_MASK_EN
            cfgMask_q    <= '0;
`endif
        end else begin
            cfgPattern_q <= cfgPattern_d;
            cfgLen_q     <= cfgLen_d;
            cfgOverlap_q <= cfgOverlap_d;
            history_q    <= history_d;
            fill_q       <= fill_d;
            detect_q     <= detect_d;
            cfgErr_q     <= cfgErr_d;
            count_q      <= count_d;
`ifdef SEQ_DETECT_MASK_EN
            cfgMask_q    <= cfgMask_d;
`endif
        end
    end

    assign detector_out = detect_q;
    assign match_count  = count_q;
    assign armed        = (state_q == RUN);
    assign cfg_err      = cfgErr_q;

endmodule
